// File: rtl/acq_sequencer_if.sv
// Control, status and BRAM write-port signals of the acquisition sequencer.
// The master side is the sequencer itself; the slave side is whoever drives it.
interface acq_sequencer_if #(
  parameter int DECIM_WIDTH = 16,
  parameter int DELAY_WIDTH = 32
);
  logic                   start;
  logic                   stop;
  logic                   single;
  logic                   trig;
  logic [DECIM_WIDTH-1:0] decim;
  logic [DELAY_WIDTH-1:0] trig_delay;
  logic [31:0]            address;
  logic [3:0]             wen;
  logic                   busy;
  logic                   done;
  logic [2:0]             state;
  logic [31:0]            trig_count;

  modport master (
    input  start, stop, single, trig, decim, trig_delay,
    output address, wen, busy, done, state, trig_count
  );

  modport slave (
    output start, stop, single, trig, decim, trig_delay,
    input  address, wen, busy, done, state, trig_count
  );
endinterface

// File: rtl/acq_sequencer.sv
// Triggered BRAM capture sequencer: arm, wait for a trigger edge, optional delay,
// then write 2^COUNT_WIDTH decimated samples; single-shot or continuous re-arm.
module acq_sequencer #(
  parameter int COUNT_WIDTH = 13,
  parameter int DECIM_WIDTH = 16,
  parameter int DELAY_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  acq_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_WORD = {COUNT_WIDTH{1'b1}};

  state_t                 state_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [DECIM_WIDTH-1:0] dcnt_r;
  logic [DELAY_WIDTH-1:0] dly_r;
  logic [DECIM_WIDTH-1:0] decim_l_r;
  logic [DELAY_WIDTH-1:0] delay_l_r;
  logic                   single_l_r;
  logic                   trig_reg_r;
  logic                   last_r;
  logic [31:0]            trig_count_r;
  logic                   done_r;
  logic                   busy_r;
  logic [3:0]             wen_r;
  logic [31:0]            address_r;

  logic                   edge_s;
  logic [DECIM_WIDTH-1:0] n_eff_s;
  logic                   dcnt_hit_s;
  logic                   write_now_s;

  assign edge_s     = bus.trig & ~trig_reg_r;
  assign n_eff_s    = (decim_l_r == '0) ? {{(DECIM_WIDTH-1){1'b0}}, 1'b1} : decim_l_r;
  // Widened compare so dcnt+1 cannot wrap for the largest decimation factor.
  assign dcnt_hit_s = ({1'b0, dcnt_r} + {{DECIM_WIDTH{1'b0}}, 1'b1}) == {1'b0, n_eff_s};

  // A write is scheduled for the next cycle: capture entry or a decimation strobe.
  assign write_now_s = ((state_r == ARMED)   && edge_s && (delay_l_r == '0)) ||
                       ((state_r == DELAY)   && (dly_r == '0)) ||
                       ((state_r == CAPTURE) && !last_r && dcnt_hit_s);

  // Sequencer state machine with registered BRAM port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      count_r      <= '0;
      dcnt_r       <= '0;
      dly_r        <= '0;
      decim_l_r    <= '0;
      delay_l_r    <= '0;
      single_l_r   <= 1'b0;
      trig_reg_r   <= 1'b0;
      last_r       <= 1'b0;
      trig_count_r <= 32'd0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      wen_r        <= 4'h0;
      address_r    <= 32'd0;
    end else begin
      trig_reg_r <= bus.trig;
      wen_r      <= 4'h0;
      if (bus.stop) begin
        state_r   <= IDLE;
        count_r   <= '0;
        dcnt_r    <= '0;
        dly_r     <= '0;
        last_r    <= 1'b0;
        busy_r    <= 1'b0;
        address_r <= 32'd0;
      end else begin
        case (state_r)
          IDLE, DONE: begin
            if (bus.start) begin
              state_r    <= ARMED;
              busy_r     <= 1'b1;
              done_r     <= 1'b0;
              count_r    <= '0;
              decim_l_r  <= bus.decim;
              delay_l_r  <= bus.trig_delay;
              single_l_r <= bus.single;
            end else begin
              state_r <= state_r;
            end
          end
          ARMED: begin
            if (edge_s) begin
              trig_count_r <= trig_count_r + 32'd1;
              if (delay_l_r != '0) begin
                state_r <= DELAY;
                dly_r   <= delay_l_r - {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
              end else begin
                dly_r <= '0;
              end
            end else begin
              state_r <= ARMED;
            end
          end
          DELAY: begin
            if (dly_r != '0) begin
              dly_r <= dly_r - {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              dly_r <= '0;
            end
          end
          CAPTURE: begin
            if (last_r) begin
              last_r <= 1'b0;
              dcnt_r <= '0;
              if (single_l_r) begin
                state_r <= DONE;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                state_r <= ARMED;
              end
            end else begin
              dcnt_r <= dcnt_r + {{(DECIM_WIDTH-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase

        if (write_now_s) begin
          state_r   <= CAPTURE;
          wen_r     <= 4'hF;
          address_r <= {{(30-COUNT_WIDTH){1'b0}}, count_r, 2'b00};
          count_r   <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          last_r    <= (count_r == LAST_WORD);
          dcnt_r    <= '0;
        end
      end
    end
  end

  assign bus.address    = address_r;
  assign bus.wen        = wen_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.state      = state_r;
  assign bus.trig_count = trig_count_r;
endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with an 8-word capture; one task per scenario,
// expected values hand-derived from the cycle timing of each scenario.
module tb_acq_sequencer;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  acq_sequencer_if #(.DECIM_WIDTH(16), .DELAY_WIDTH(32)) bus ();

  acq_sequencer #(.COUNT_WIDTH(3), .DECIM_WIDTH(16), .DELAY_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.single = 1'b0; bus.trig = 1'b0;
    bus.decim = 16'd0; bus.trig_delay = 32'd0;
    step(); step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    checks++; if (bus.wen !== 4'h0) begin errors++; $display("FAIL rst_wen got=%h exp=0", bus.wen); end
    checks++; if (bus.address !== 32'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", bus.address); end
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got=%b exp=00", {bus.busy, bus.done}); end
    checks++; if (bus.trig_count !== 32'd0) begin errors++; $display("FAIL rst_tc got=%0d exp=0", bus.trig_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_shot();
    bus.decim = 16'd0; bus.trig_delay = 32'd0; bus.single = 1'b1; bus.trig = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if ({bus.state, bus.busy} !== {3'd1, 1'b1}) begin errors++; $display("FAIL ss_armed got=%0d/%b exp=1/1", bus.state, bus.busy); end
    bus.trig = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.state, bus.wen, bus.address} !== {3'd3, 4'hF, 32'(i * 4)}) begin
        errors++; $display("FAIL ss_write%0d got st=%0d wen=%h addr=%0d exp st=3 wen=f addr=%0d", i, bus.state, bus.wen, bus.address, i * 4);
      end
      step();
    end
    checks++; if ({bus.state, bus.done, bus.busy, bus.wen} !== {3'd4, 1'b1, 1'b0, 4'h0}) begin
      errors++; $display("FAIL ss_done got st=%0d done=%b busy=%b wen=%h exp st=4 done=1 busy=0 wen=0", bus.state, bus.done, bus.busy, bus.wen); end
    checks++; if (bus.trig_count !== 32'd1) begin errors++; $display("FAIL ss_tc got=%0d exp=1", bus.trig_count); end
    bus.trig = 1'b0;
    step();
  endtask

  task automatic test_decim_delay();
    bus.decim = 16'd3; bus.trig_delay = 32'd5; bus.single = 1'b1; bus.trig = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if ({bus.state, bus.done} !== {3'd1, 1'b0}) begin errors++; $display("FAIL dd_rearm got st=%0d done=%b exp st=1 done=0", bus.state, bus.done); end
    // config changes after start must not matter
    bus.decim = 16'd1; bus.trig_delay = 32'd0;
    bus.trig = 1'b1;
    step();
    for (int j = 1; j <= 5; j++) begin
      checks++;
      if ({bus.state, bus.wen} !== {3'd2, 4'h0}) begin
        errors++; $display("FAIL dd_delay%0d got st=%0d wen=%h exp st=2 wen=0", j, bus.state, bus.wen);
      end
      step();
    end
    checks++; if ({bus.state, bus.wen, bus.address} !== {3'd3, 4'hF, 32'd0}) begin
      errors++; $display("FAIL dd_first got st=%0d wen=%h addr=%0d exp st=3 wen=f addr=0", bus.state, bus.wen, bus.address); end
    for (int w = 1; w < 8; w++) begin
      for (int g = 0; g < 2; g++) begin
        step();
        checks++; if (bus.wen !== 4'h0) begin errors++; $display("FAIL dd_gap%0d_%0d got wen=%h exp 0", w, g, bus.wen); end
      end
      step();
      checks++; if ({bus.wen, bus.address} !== {4'hF, 32'(w * 4)}) begin
        errors++; $display("FAIL dd_write%0d got wen=%h addr=%0d exp wen=f addr=%0d", w, bus.wen, bus.address, w * 4); end
    end
    step();
    checks++; if ({bus.state, bus.done} !== {3'd4, 1'b1}) begin errors++; $display("FAIL dd_done got st=%0d done=%b exp st=4 done=1", bus.state, bus.done); end
    checks++; if (bus.trig_count !== 32'd2) begin errors++; $display("FAIL dd_tc got=%0d exp=2", bus.trig_count); end
    bus.trig = 1'b0;
    step();
  endtask

  task automatic test_continuous();
    bus.decim = 16'd0; bus.trig_delay = 32'd0; bus.single = 1'b0; bus.trig = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.trig = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.wen, bus.address} !== {4'hF, 32'(i * 4)}) begin
        errors++; $display("FAIL ct_write%0d got wen=%h addr=%0d exp wen=f addr=%0d", i, bus.wen, bus.address, i * 4);
      end
      if (i == 1) bus.trig = 1'b0;
      if (i == 3) bus.trig = 1'b1;
      bus.start = (i == 5);
      step();
    end
    bus.start = 1'b0;
    checks++; if ({bus.state, bus.busy, bus.done} !== {3'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ct_rearm got st=%0d busy=%b done=%b exp st=1 busy=1 done=0", bus.state, bus.busy, bus.done); end
    checks++; if (bus.trig_count !== 32'd3) begin errors++; $display("FAIL ct_tc1 got=%0d exp=3", bus.trig_count); end
    bus.trig = 1'b0;
    step();
    bus.trig = 1'b1;
    step();
    checks++; if ({bus.state, bus.wen, bus.address} !== {3'd3, 4'hF, 32'd0}) begin
      errors++; $display("FAIL ct_recap got st=%0d wen=%h addr=%0d exp st=3 wen=f addr=0", bus.state, bus.wen, bus.address); end
    checks++; if (bus.trig_count !== 32'd4) begin errors++; $display("FAIL ct_tc2 got=%0d exp=4", bus.trig_count); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL ct_stop got st=%0d exp=0", bus.state); end
  endtask

  task automatic test_stop();
    bus.decim = 16'd0; bus.trig_delay = 32'd0; bus.single = 1'b1; bus.trig = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.trig = 1'b1;
    step(); step(); step(); step();
    checks++; if ({bus.wen, bus.address} !== {4'hF, 32'd12}) begin
      errors++; $display("FAIL sp_pre got wen=%h addr=%0d exp wen=f addr=12", bus.wen, bus.address); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checks++; if ({bus.state, bus.wen, bus.address, bus.done, bus.busy} !== {3'd0, 4'h0, 32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sp_idle got st=%0d wen=%h addr=%0d done=%b busy=%b exp 0", bus.state, bus.wen, bus.address, bus.done, bus.busy); end
    bus.trig = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if ({bus.state, bus.busy} !== {3'd1, 1'b1}) begin errors++; $display("FAIL sp_rearm got st=%0d busy=%b exp 1/1", bus.state, bus.busy); end
    bus.trig = 1'b1;
    step();
    checks++; if ({bus.wen, bus.address} !== {4'hF, 32'd0}) begin
      errors++; $display("FAIL sp_restart got wen=%h addr=%0d exp wen=f addr=0", bus.wen, bus.address); end
    checks++; if (bus.trig_count !== 32'd6) begin errors++; $display("FAIL sp_tc got=%0d exp=6", bus.trig_count); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid_delay();
    bus.decim = 16'd0; bus.trig_delay = 32'd10; bus.single = 1'b1; bus.trig = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.trig = 1'b1;
    step(); step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL rd_delay got st=%0d exp=2", bus.state); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.state, bus.wen, bus.address, bus.busy, bus.done, bus.trig_count} !== 43'd0) begin
      errors++; $display("FAIL rd_async got st=%0d wen=%h addr=%0d busy=%b done=%b tc=%0d exp all 0", bus.state, bus.wen, bus.address, bus.busy, bus.done, bus.trig_count); end
    step();
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    checks++; if ({bus.state, bus.trig_count} !== {3'd1, 32'd0}) begin
      errors++; $display("FAIL rd_noedge got st=%0d tc=%0d exp st=1 tc=0", bus.state, bus.trig_count); end
    bus.trig = 1'b0;
    step();
    bus.trig = 1'b1;
    step();
    checks++; if ({bus.state, bus.trig_count} !== {3'd2, 32'd1}) begin
      errors++; $display("FAIL rd_edge got st=%0d tc=%0d exp st=2 tc=1", bus.state, bus.trig_count); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.trig = 1'b0;
  endtask

  task automatic test_start_stop();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++; if ({bus.state, bus.busy} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL ssp_idle got st=%0d busy=%b exp st=0 busy=0", bus.state, bus.busy); end
    step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL ssp_hold got st=%0d exp=0", bus.state); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_shot();
    test_decim_delay();
    test_continuous();
    test_stop();
    test_reset_mid_delay();
    test_start_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
